// File: rtl/qerv_dbus_bridge.sv
// qerv_dbus_bridge: registered Wishbone-classic stage for the qerv data bus.
// The core request launches one bus cycle. The bus signals stay stable until
// the slave acks. The block then returns registered read data with a one-cycle
// completion pulse.
// Optional feature macro: QERV_DBUS_TIMEOUT_EN. When it is defined, a REQ that
// waits more than TIMEOUT cycles for an ack ends with an error ack.
module qerv_dbus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_cpu_adr,
  input  logic [31:0] i_cpu_dat,
  input  logic [3:0]  i_cpu_sel,
  input  logic        i_cpu_we,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic        o_cpu_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Timeout limit narrowed to the 16-bit counter width (legal range 1..65535)
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t r_state;
  logic   r_abort;    // core withdrew i_cpu_cyc during the current REQ
  logic   w_abort;    // abort seen now or earlier in this REQ
  logic   w_expired;  // timeout reached in this REQ cycle

  assign w_abort = r_abort | ~i_cpu_cyc;

`ifdef QERV_DBUS_TIMEOUT_EN
  logic [15:0] r_cnt;

  assign w_expired = (r_state == ST_REQ) && (r_cnt == TIMEOUT_C);

  // Count REQ cycles without an ack; restart at every launch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_IDLE) && i_cpu_cyc) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_REQ) && !i_wb_ack && !w_expired) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  // Without the timeout feature REQ waits for the slave indefinitely
  assign w_expired = 1'b0;
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_C;
`endif

  // Bus FSM with all bus and core-side outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_abort   <= 1'b0;
      o_cpu_rdt <= 32'd0;
      o_cpu_ack <= 1'b0;
      o_cpu_err <= 1'b0;
      o_wb_adr  <= 32'd0;
      o_wb_dat  <= 32'd0;
      o_wb_sel  <= 4'd0;
      o_wb_we   <= 1'b0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_cpu_ack <= 1'b0;
          o_cpu_err <= 1'b0;
          if (i_cpu_cyc) begin
            o_wb_adr <= i_cpu_adr;
            o_wb_dat <= i_cpu_dat;
            o_wb_sel <= i_cpu_sel;
            o_wb_we  <= i_cpu_we;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            r_abort  <= 1'b0;
            r_state  <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_REQ: begin
          r_abort <= w_abort;
          if (i_wb_ack) begin
            // A slave ack in the expiry cycle wins over the timeout
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            if (!o_wb_we) begin
              o_cpu_rdt <= i_wb_rdt;
            end else begin
              o_cpu_rdt <= o_cpu_rdt;
            end
            o_cpu_err <= 1'b0;
            if (w_abort) begin
              o_cpu_ack <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              o_cpu_ack <= 1'b1;
              r_state   <= ST_RESP;
            end
          end else if (w_expired) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_cpu_rdt <= 32'd0;
            if (w_abort) begin
              o_cpu_ack <= 1'b0;
              o_cpu_err <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              o_cpu_ack <= 1'b1;
              o_cpu_err <= 1'b1;
              r_state   <= ST_RESP;
            end
          end else begin
            r_state <= ST_REQ;
          end
        end

        ST_RESP: begin
          // The ack pulse lasts one cycle; the core drops i_cpu_cyc next
          o_cpu_ack <= 1'b0;
          o_cpu_err <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          o_cpu_ack <= 1'b0;
          o_cpu_err <= 1'b0;
          o_wb_cyc  <= 1'b0;
          o_wb_stb  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_dbus_bridge.sv
// Directed self-checking bench for qerv_dbus_bridge.
// When the design is built with QERV_DBUS_TIMEOUT_EN, the bench also covers the timeout path with TIMEOUT=4.
module tb_qerv_dbus_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_dat;
  logic [3:0]  cpu_sel;
  logic        cpu_we;
  logic        cpu_cyc;
  logic [31:0] cpu_rdt;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;

  qerv_dbus_bridge #(.TIMEOUT(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cpu_adr (cpu_adr),
    .i_cpu_dat (cpu_dat),
    .i_cpu_sel (cpu_sel),
    .i_cpu_we  (cpu_we),
    .i_cpu_cyc (cpu_cyc),
    .o_cpu_rdt (cpu_rdt),
    .o_cpu_ack (cpu_ack),
    .o_cpu_err (cpu_err),
    .o_wb_adr  (wb_adr),
    .o_wb_dat  (wb_dat),
    .o_wb_sel  (wb_sel),
    .o_wb_we   (wb_we),
    .o_wb_cyc  (wb_cyc),
    .o_wb_stb  (wb_stb),
    .i_wb_rdt  (wb_rdt),
    .i_wb_ack  (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ack pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) ack_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load: launch, wait `waits` cycles, slave acks with `data`
  task automatic do_load(input logic [31:0] adr, input logic [31:0] data, input int waits);
    cpu_adr = adr; cpu_sel = 4'hF; cpu_we = 1'b0; cpu_cyc = 1'b1;
    step();
    check_eq("ld_cyc", {31'd0, wb_cyc}, 32'd1);
    check_eq("ld_adr", wb_adr, adr);
    for (int i = 0; i < waits; i++) begin
      step();
      check_eq("ld_wait_cyc", {31'd0, wb_cyc}, 32'd1);
    end
    wb_ack = 1'b1; wb_rdt = data;
    step();
    check_eq("ld_ack", {31'd0, cpu_ack}, 32'd1);
    check_eq("ld_err", {31'd0, cpu_err}, 32'd0);
    check_eq("ld_rdt", cpu_rdt, data);
    check_eq("ld_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    wb_ack = 1'b0; cpu_cyc = 1'b0;
    step();
    check_eq("ld_ack_end", {31'd0, cpu_ack}, 32'd0);
  endtask

  initial begin
    int acks0;
    rst_n = 1'b0; cpu_adr = 32'd0; cpu_dat = 32'd0; cpu_sel = 4'd0;
    cpu_we = 1'b0; cpu_cyc = 1'b0; wb_rdt = 32'd0; wb_ack = 1'b0;
    step(); step();
    check_eq("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check_eq("rst_stb", {31'd0, wb_stb}, 32'd0);
    check_eq("rst_ack", {31'd0, cpu_ack}, 32'd0);
    check_eq("rst_rdt", cpu_rdt, 32'd0);
    check_eq("rst_adr", wb_adr, 32'd0);
    rst_n = 1'b1;
    step();

    // Load, slave acks in cycle 1
    cpu_adr = 32'h0000_0100; cpu_sel = 4'b0011; cpu_we = 1'b0; cpu_cyc = 1'b1;
    step();
    check_eq("t1_cyc1", {31'd0, wb_cyc}, 32'd1);
    check_eq("t1_stb1", {31'd0, wb_stb}, 32'd1);
    check_eq("t1_adr", wb_adr, 32'h0000_0100);
    check_eq("t1_sel", {28'd0, wb_sel}, 32'd3);
    check_eq("t1_we", {31'd0, wb_we}, 32'd0);
    check_eq("t1_noack1", {31'd0, cpu_ack}, 32'd0);
    wb_ack = 1'b1; wb_rdt = 32'hDEAD_BEEF;
    step();
    check_eq("t1_cyc2", {31'd0, wb_cyc}, 32'd0);
    check_eq("t1_ack2", {31'd0, cpu_ack}, 32'd1);
    check_eq("t1_err2", {31'd0, cpu_err}, 32'd0);
    check_eq("t1_rdt", cpu_rdt, 32'hDEAD_BEEF);
    wb_ack = 1'b0; cpu_cyc = 1'b0; wb_rdt = 32'd0;
    step();
    check_eq("t1_ack3", {31'd0, cpu_ack}, 32'd0);
    check_eq("t1_cyc3", {31'd0, wb_cyc}, 32'd0);
    step();

    // Store, 5 wait cycles, read data must not be captured
    acks0 = ack_cnt;
    cpu_adr = 32'h0000_0204; cpu_dat = 32'h1234_5678; cpu_sel = 4'b1000;
    cpu_we = 1'b1; cpu_cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t2_cyc", {31'd0, wb_cyc}, 32'd1);
      check_eq("t2_dat", wb_dat, 32'h1234_5678);
      check_eq("t2_adr", wb_adr, 32'h0000_0204);
      check_eq("t2_sel", {28'd0, wb_sel}, 32'h8);
      check_eq("t2_we", {31'd0, wb_we}, 32'd1);
      check_eq("t2_noack", {31'd0, cpu_ack}, 32'd0);
    end
    wb_ack = 1'b1; wb_rdt = 32'hFFFF_0000;
    step();
    check_eq("t2_ack", {31'd0, cpu_ack}, 32'd1);
    check_eq("t2_rdt_hold", cpu_rdt, 32'hDEAD_BEEF);
    wb_ack = 1'b0; cpu_cyc = 1'b0; cpu_we = 1'b0;
    step(); step();
    check_eq("t2_one_pulse", ack_cnt - acks0, 32'd1);
    check_eq("t2_rdt_idle", cpu_rdt, 32'hDEAD_BEEF);

    // Back-to-back loads
    acks0 = ack_cnt;
    do_load(32'h0000_0010, 32'h0000_000A, 0);
    do_load(32'h0000_0014, 32'h0000_000B, 1);
    step();
    check_eq("t3_two_pulses", ack_cnt - acks0, 32'd2);
    check_eq("t3_rdt", cpu_rdt, 32'h0000_000B);

    // Asynchronous reset in REQ
    cpu_adr = 32'h0000_0300; cpu_we = 1'b0; cpu_cyc = 1'b1;
    step();
    check_eq("t4_cyc_pre", {31'd0, wb_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_cyc_async", {31'd0, wb_cyc}, 32'd0);
    check_eq("t4_rdt_async", cpu_rdt, 32'd0);
    check_eq("t4_adr_async", wb_adr, 32'd0);
    cpu_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_load(32'h0000_0400, 32'hCAFE_0001, 2);

    // Abort: core drops cyc in REQ, slave acks later
    acks0 = ack_cnt;
    cpu_adr = 32'h0000_0500; cpu_we = 1'b0; cpu_cyc = 1'b1;
    step();
    check_eq("t6_cyc", {31'd0, wb_cyc}, 32'd1);
    cpu_cyc = 1'b0;
    step();
    check_eq("t6_cyc_held", {31'd0, wb_cyc}, 32'd1);
    wb_ack = 1'b1; wb_rdt = 32'h0000_55AA;
    step();
    check_eq("t6_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    check_eq("t6_rdt", cpu_rdt, 32'h0000_55AA);
    wb_ack = 1'b0;
    step(); step();
    check_eq("t6_no_ack", ack_cnt - acks0, 32'd0);
    check_eq("t6_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    do_load(32'h0000_0600, 32'h0BAD_F00D, 0);

`ifdef QERV_DBUS_TIMEOUT_EN
    // Silent slave: timeout after 4 counted cycles
    cpu_adr = 32'h0000_0700; cpu_we = 1'b0; cpu_cyc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("to_wait_cyc", {31'd0, wb_cyc}, 32'd1);
      check_eq("to_wait_ack", {31'd0, cpu_ack}, 32'd0);
    end
    step();
    check_eq("to_cyc", {31'd0, wb_cyc}, 32'd0);
    check_eq("to_ack", {31'd0, cpu_ack}, 32'd1);
    check_eq("to_err", {31'd0, cpu_err}, 32'd1);
    check_eq("to_rdt", cpu_rdt, 32'd0);
    cpu_cyc = 1'b0;
    step(); step();
    // Ack on the expiry cycle wins
    cpu_cyc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("toa_wait_ack", {31'd0, cpu_ack}, 32'd0);
    end
    wb_ack = 1'b1; wb_rdt = 32'h1357_9BDF;
    step();
    check_eq("toa_ack", {31'd0, cpu_ack}, 32'd1);
    check_eq("toa_err", {31'd0, cpu_err}, 32'd0);
    check_eq("toa_rdt", cpu_rdt, 32'h1357_9BDF);
    wb_ack = 1'b0; cpu_cyc = 1'b0;
    step(); step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qerv_dbus_bridge.md
# qerv_dbus_bridge

Registered Wishbone-classic data-bus stage between the qerv core's data-bus master (address, pre-shifted store data, and the byte-lane select produced by the memory interface) and the external slave. Launches one transaction per core request, holds bus signals stable until the slave acks, and returns registered read data with a single-cycle ack. An optional timeout converts hung transactions into an error ack.

## Interface
Parameters:
- TIMEOUT, 255: cycles in REQ without i_wb_ack before a timeout fires (range 1..65535); ignored unless QERV_DBUS_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cpu_adr  in  32  byte address; bits [1:0] passed through unchanged
- i_cpu_dat  in  32  store data, already lane-shifted
- i_cpu_sel  in  4  byte-lane select from the memory interface
- i_cpu_we  in  1  1 = store, 0 = load
- i_cpu_cyc  in  1  request valid; held until o_cpu_ack
- o_cpu_rdt  out  32  registered load data
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_err  out  1  qualifies o_cpu_ack; 1 = timed out
- o_wb_adr  out  32  bus address
- o_wb_dat  out  32  bus write data
- o_wb_sel  out  4  bus byte select
- o_wb_we  out  1  bus write enable
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe, always equal to o_wb_cyc
- i_wb_rdt  in  32  bus read data
- i_wb_ack  in  1  bus acknowledge

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if i_cpu_cyc=1, latch adr/dat/sel/we into the o_wb_* registers, set o_wb_cyc=o_wb_stb=1, clear timeout counter, go to REQ. Otherwise hold all outputs.
- REQ: o_wb_* remain stable. On i_wb_ack=1: clear o_wb_cyc/stb; if o_wb_we=0, load o_cpu_rdt<=i_wb_rdt; go to RESP.
- RESP: o_cpu_ack=1 for exactly this cycle (o_cpu_err per cause); unconditionally return to IDLE. The core drops i_cpu_cyc the cycle after ack, so IDLE does not relaunch the completed request.
- Abort: if i_cpu_cyc falls while in REQ, the bus transaction still completes; on i_wb_ack go to IDLE directly, no o_cpu_ack, o_cpu_rdt is still updated for loads.
- o_cpu_rdt holds its value across stores and idle cycles.
- No alignment checking; misaligned requests never reach this block.
- Reset (any time, including mid-REQ): immediately state=IDLE, all outputs 0 (o_wb_cyc, o_wb_stb, o_cpu_ack, o_cpu_err, o_cpu_rdt, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we). The slave must tolerate the dropped cycle.

## Timing
- Request sampled in IDLE at cycle 0 -> o_wb_cyc=1 from cycle 1.
- Slave ack at cycle k (k>=1) -> o_wb_cyc=0 and o_cpu_ack=1 at cycle k+1.
- Minimum request-to-ack latency: 2 cycles (slave acks in cycle 1). Back-to-back requests: next launch no earlier than cycle k+3.
- Every output is a flop output; no combinational path from i_wb_* or i_cpu_* to any output.

## Configuration
- QERV_DBUS_TIMEOUT_EN defined: 16-bit counter increments each REQ cycle without i_wb_ack. When it equals TIMEOUT with i_wb_ack=0: drop o_wb_cyc/stb, set o_cpu_rdt=0, go to RESP with o_cpu_err=1. i_wb_ack in the same cycle as expiry wins: normal completion, o_cpu_err=0. Abort-path timeout returns to IDLE without ack.
- Not defined: no counter, o_cpu_err tied 0, REQ waits indefinitely.

## Test plan
- Load, sel=4'b0011, adr=0x100, slave acks in cycle 1 with rdt=0xDEADBEEF -> o_wb_cyc high cycle 1 only, o_cpu_ack cycle 2, o_cpu_rdt=0xDEADBEEF, o_cpu_err=0.
- Store dat=0x12345678, sel=4'b1000, ack after 5 wait cycles -> o_wb_* stable all 6 REQ cycles, one ack pulse, o_cpu_rdt unchanged.
- Two back-to-back loads (0xA, then 0xB) -> two separate bus cycles, exactly two ack pulses, o_cpu_rdt=0xB at end.
- i_rst_n low while in REQ -> o_wb_cyc=0 without waiting for a clock edge; after release, new request launches normally.
- With QERV_DBUS_TIMEOUT_EN, TIMEOUT=4, slave silent -> o_wb_cyc drops, o_cpu_ack=1, o_cpu_err=1, o_cpu_rdt=0. Repeat with i_wb_ack on expiry cycle -> o_cpu_err=0, data captured.
- Core drops i_cpu_cyc mid-REQ, slave acks later -> no o_cpu_ack, state back to IDLE.
